// File: rtl/rx_carrier_nco.sv
// rtl/rx_carrier_nco.sv - receive-path quadrature carrier NCO (quarter-wave table, quadrant folding).
// Optional macro NCO_DITHER_EN adds LFSR phase dither ahead of table-phase truncation.
module rx_carrier_nco #(
  parameter int               ACC_W   = 16,
  parameter logic [ACC_W-1:0] FCW_RST = 16'h0400
) (
  input  logic             CLK_2,
  input  logic             RST,
  input  logic             EN,
  input  logic             FCW_LD,
  input  logic [ACC_W-1:0] FCW_IN,
  input  logic             PHASE_CLR,
  input  logic [5:0]       POFF_IN,
  output logic [5:0]       SIN_C,
  output logic [5:0]       COS_C,
  output logic             NCO_VALID
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] fcw_q, fcw_d;
  logic [5:0]       sin_q, sin_d;
  logic [5:0]       cos_q, cos_d;
  logic             nco_valid_q, nco_valid_d;
  logic [5:0]       acc_top;
  logic [5:0]       tbl_ph;

  function automatic logic [4:0] qw_table(input logic [4:0] idx);
    logic [4:0] v;
    case (idx)
      5'd0:    v = 5'd0;
      5'd1:    v = 5'd3;
      5'd2:    v = 5'd6;
      5'd3:    v = 5'd9;
      5'd4:    v = 5'd12;
      5'd5:    v = 5'd15;
      5'd6:    v = 5'd17;
      5'd7:    v = 5'd20;
      5'd8:    v = 5'd22;
      5'd9:    v = 5'd24;
      5'd10:   v = 5'd26;
      5'd11:   v = 5'd27;
      5'd12:   v = 5'd29;
      5'd13:   v = 5'd30;
      5'd14:   v = 5'd30;
      5'd15:   v = 5'd31;
      default: v = 5'd31;
    endcase
    return v;
  endfunction

  // Odd quadrants walk the quarter table backwards; the upper half is negated.
  function automatic logic [5:0] fold_sine(input logic [5:0] ph);
    logic [4:0] k;
    logic [4:0] idx;
    logic [5:0] mag;
    k   = {1'b0, ph[3:0]};
    idx = ph[4] ? (5'd16 - k) : k;
    mag = {1'b0, qw_table(idx)};
    return ph[5] ? (6'd0 - mag) : mag;
  endfunction

`ifdef NCO_DITHER_EN
  logic [7:0]       lfsr_q, lfsr_d;
  logic [ACC_W-7:0] low_sum;
  logic             dith_carry;

  // Only the carry out of the truncated bits can reach the table phase.
  always_comb begin
    low_sum    = acc_q[ACC_W-7:0] + {{(ACC_W-14){1'b0}}, lfsr_q};
    dith_carry = (low_sum < acc_q[ACC_W-7:0]);
    acc_top    = acc_q[ACC_W-1 -: 6] + {5'd0, dith_carry};
    lfsr_d     = lfsr_q;
    if (EN) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge CLK_2 or negedge RST) begin
    if (!RST) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  always_comb begin
    acc_top = acc_q[ACC_W-1 -: 6];
  end
`endif

  always_comb begin
    tbl_ph      = acc_top + POFF_IN;
    acc_d       = acc_q;
    fcw_d       = fcw_q;
    sin_d       = sin_q;
    cos_d       = cos_q;
    nco_valid_d = nco_valid_q;
    if (EN) begin
      acc_d       = acc_q + fcw_q;
      sin_d       = fold_sine(tbl_ph);
      cos_d       = fold_sine(tbl_ph + 6'd16);
      nco_valid_d = 1'b1;
    end
    if (PHASE_CLR) begin
      acc_d = '0;
    end
    if (FCW_LD) begin
      fcw_d = FCW_IN;
    end
  end

  always_ff @(posedge CLK_2 or negedge RST) begin
    if (!RST) begin
      acc_q       <= '0;
      fcw_q       <= FCW_RST;
      sin_q       <= 6'd0;
      cos_q       <= 6'd0;
      nco_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      fcw_q       <= fcw_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
      nco_valid_q <= nco_valid_d;
    end
  end

  assign SIN_C     = sin_q;
  assign COS_C     = cos_q;
  assign NCO_VALID = nco_valid_q;

endmodule

// File: tb/tb_rx_carrier_nco.sv
// tb/tb_rx_carrier_nco.sv - self-checking bench for rx_carrier_nco against a sine-table model.
module tb_rx_carrier_nco;

  logic        CLK_2;
  logic        RST;
  logic        EN;
  logic        FCW_LD;
  logic [15:0] FCW_IN;
  logic        PHASE_CLR;
  logic [5:0]  POFF_IN;
  logic [5:0]  SIN_C;
  logic [5:0]  COS_C;
  logic        NCO_VALID;

  int n_vec;
  int n_err;

  int tbl [0:16] = '{0, 3, 6, 9, 12, 15, 17, 20, 22, 24, 26, 27, 29, 30, 30, 31, 31};

  int          m_acc;
  int          m_fcw;
  logic [5:0]  m_sin;
  logic [5:0]  m_cos;
  logic        m_valid;

  rx_carrier_nco #(.ACC_W(16), .FCW_RST(16'h0400)) dut (
    .CLK_2     (CLK_2),
    .RST       (RST),
    .EN        (EN),
    .FCW_LD    (FCW_LD),
    .FCW_IN    (FCW_IN),
    .PHASE_CLR (PHASE_CLR),
    .POFF_IN   (POFF_IN),
    .SIN_C     (SIN_C),
    .COS_C     (COS_C),
    .NCO_VALID (NCO_VALID)
  );

  initial CLK_2 = 1'b0;
  always #5 CLK_2 = ~CLK_2;

  function automatic int ref_sin(int p);
    if (p <= 16)      return tbl[p];
    else if (p <= 32) return tbl[32 - p];
    else if (p <= 48) return -tbl[p - 32];
    else              return -tbl[64 - p];
  endfunction

  task automatic model_reset();
    m_acc   = 0;
    m_fcw   = 16'h0400;
    m_sin   = 6'd0;
    m_cos   = 6'd0;
    m_valid = 1'b0;
  endtask

  // One clock edge with the current inputs; model and DUT both advance.
  task automatic advance();
    int         p;
    int         nacc;
    int         nfcw;
    logic [5:0] ns;
    logic [5:0] nc;
    logic       nv;
    ns   = m_sin;
    nc   = m_cos;
    nv   = m_valid;
    nacc = m_acc;
    nfcw = m_fcw;
    if (EN) begin
      p    = ((m_acc / 1024) + int'(POFF_IN)) % 64;
      ns   = 6'(ref_sin(p));
      nc   = 6'(ref_sin((p + 16) % 64));
      nv   = 1'b1;
      nacc = (m_acc + m_fcw) % 65536;
    end
    if (PHASE_CLR) nacc = 0;
    if (FCW_LD) nfcw = int'(FCW_IN);
    @(posedge CLK_2);
    #1;
    m_acc   = nacc;
    m_fcw   = nfcw;
    m_sin   = ns;
    m_cos   = nc;
    m_valid = nv;
  endtask

  task automatic test_reset();
    RST = 1'b0; EN = 1'b1; FCW_LD = 1'b0; FCW_IN = 16'h0; PHASE_CLR = 1'b0; POFF_IN = 6'd0;
    model_reset();
    repeat (3) @(posedge CLK_2);
    #1;
    n_vec++;
    if ({SIN_C, COS_C, NCO_VALID} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_state: got sin=%0d cos=%0d valid=%0b, want 0 0 0", $signed(SIN_C), $signed(COS_C), NCO_VALID);
    end
    RST = 1'b1;
    advance();
    n_vec++;
    if (SIN_C !== 6'd0 || COS_C !== 6'd31 || NCO_VALID !== 1'b1) begin
      n_err++;
      $display("FAIL first_output: got (%0d,%0d) valid=%0b, want (0,31) valid=1", $signed(SIN_C), $signed(COS_C), NCO_VALID);
    end
  endtask

  task automatic test_default_sweep();
    logic [5:0] es;
    logic [5:0] ec;
    for (int i = 1; i <= 64; i++) begin
      advance();
      n_vec++;
      if (SIN_C !== m_sin || COS_C !== m_cos || NCO_VALID !== m_valid) begin
        n_err++;
        $display("FAIL sweep_%0d: got (%0d,%0d,%0b), want (%0d,%0d,%0b)", i, $signed(SIN_C), $signed(COS_C), NCO_VALID, $signed(m_sin), $signed(m_cos), m_valid);
      end
      if (i % 16 == 0) begin
        case (i)
          16:      begin es = 6'd31;       ec = 6'd0;        end
          32:      begin es = 6'd0;        ec = 6'(-31);     end
          48:      begin es = 6'(-31);     ec = 6'd0;        end
          default: begin es = 6'd0;        ec = 6'd31;       end
        endcase
        n_vec++;
        if (SIN_C !== es || COS_C !== ec) begin
          n_err++;
          $display("FAIL sweep_quadrant_%0d: got (%0d,%0d), want (%0d,%0d)", i, $signed(SIN_C), $signed(COS_C), $signed(es), $signed(ec));
        end
      end
    end
  endtask

  task automatic test_fcw_load();
    FCW_IN = 16'h4000; FCW_LD = 1'b1;
    advance();
    FCW_LD = 1'b0;
    for (int i = 0; i < 8; i++) begin
      advance();
      n_vec++;
      if (SIN_C !== m_sin || COS_C !== m_cos) begin
        n_err++;
        $display("FAIL fcw_load_%0d: got (%0d,%0d), want (%0d,%0d)", i, $signed(SIN_C), $signed(COS_C), $signed(m_sin), $signed(m_cos));
      end
    end
  endtask

  task automatic test_freeze();
    logic [5:0] hs;
    logic [5:0] hc;
    FCW_IN = 16'h0400; FCW_LD = 1'b1;
    advance();
    FCW_LD = 1'b0;
    advance();
    advance();
    hs = m_sin; hc = m_cos;
    EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      POFF_IN = 6'($urandom_range(0, 63));
      advance();
      n_vec++;
      if (SIN_C !== hs || COS_C !== hc || NCO_VALID !== 1'b1) begin
        n_err++;
        $display("FAIL freeze_%0d: got (%0d,%0d,%0b), want (%0d,%0d,1)", i, $signed(SIN_C), $signed(COS_C), NCO_VALID, $signed(hs), $signed(hc));
      end
    end
    EN = 1'b1; POFF_IN = 6'd0;
    for (int i = 0; i < 4; i++) begin
      advance();
      n_vec++;
      if (SIN_C !== m_sin || COS_C !== m_cos) begin
        n_err++;
        $display("FAIL resume_%0d: got (%0d,%0d), want (%0d,%0d)", i, $signed(SIN_C), $signed(COS_C), $signed(m_sin), $signed(m_cos));
      end
    end
  endtask

  task automatic test_clr_and_load();
    PHASE_CLR = 1'b1; FCW_LD = 1'b1; FCW_IN = 16'h0800;
    advance();
    PHASE_CLR = 1'b0; FCW_LD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      advance();
      n_vec++;
      if (SIN_C !== m_sin || COS_C !== m_cos) begin
        n_err++;
        $display("FAIL clr_load_%0d: got (%0d,%0d), want (%0d,%0d)", i, $signed(SIN_C), $signed(COS_C), $signed(m_sin), $signed(m_cos));
      end
      if (i == 0) begin
        n_vec++;
        if (SIN_C !== 6'd0 || COS_C !== 6'd31) begin
          n_err++;
          $display("FAIL clr_load_phase0: got (%0d,%0d), want (0,31)", $signed(SIN_C), $signed(COS_C));
        end
      end
    end
    n_vec++;
    if (SIN_C !== 6'd12 || COS_C !== 6'd29) begin
      n_err++;
      $display("FAIL clr_load_phase4: got (%0d,%0d), want (12,29)", $signed(SIN_C), $signed(COS_C));
    end
  endtask

  task automatic test_poff();
    PHASE_CLR = 1'b1;
    advance();
    PHASE_CLR = 1'b0; POFF_IN = 6'd16;
    advance();
    n_vec++;
    if (SIN_C !== 6'd31 || COS_C !== 6'd0) begin
      n_err++;
      $display("FAIL poff_16: got (%0d,%0d), want (31,0)", $signed(SIN_C), $signed(COS_C));
    end
    POFF_IN = 6'd0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      EN        = ($urandom_range(0, 3) != 0);
      FCW_LD    = ($urandom_range(0, 9) == 0);
      FCW_IN    = 16'($urandom);
      PHASE_CLR = ($urandom_range(0, 19) == 0);
      POFF_IN   = 6'($urandom_range(0, 63));
      advance();
      n_vec++;
      if (SIN_C !== m_sin || COS_C !== m_cos || NCO_VALID !== m_valid) begin
        n_err++;
        $display("FAIL random_%0d: got (%0d,%0d,%0b), want (%0d,%0d,%0b)", i, $signed(SIN_C), $signed(COS_C), NCO_VALID, $signed(m_sin), $signed(m_cos), m_valid);
      end
    end
    EN = 1'b1; FCW_LD = 1'b0; PHASE_CLR = 1'b0; POFF_IN = 6'd0;
  endtask

  task automatic test_reset_mid();
    FCW_IN = 16'h1234; FCW_LD = 1'b1;
    advance();
    FCW_LD = 1'b0;
    advance();
    advance();
    RST = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if ({SIN_C, COS_C, NCO_VALID} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_async: got sin=%0d cos=%0d valid=%0b, want 0 0 0", $signed(SIN_C), $signed(COS_C), NCO_VALID);
    end
    @(posedge CLK_2);
    #1;
    RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      advance();
      n_vec++;
      if (SIN_C !== m_sin || COS_C !== m_cos || NCO_VALID !== m_valid) begin
        n_err++;
        $display("FAIL restart_%0d: got (%0d,%0d,%0b), want (%0d,%0d,%0b)", i, $signed(SIN_C), $signed(COS_C), NCO_VALID, $signed(m_sin), $signed(m_cos), m_valid);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_default_sweep();
    test_fcw_load();
    test_freeze();
    test_clr_and_load();
    test_poff();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
